// File: rtl/dot_product_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_mac_pipe
// Description : N-lane signed dot-product engine with a registered adder tree
//               and a multi-beat packet accumulator behind a valid/ready output.
//               Optional macro SATURATE_EN clamps the output instead of truncating.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_mac_pipe #(
    parameter int N_LANES           = 36,
    parameter int IN_WIDTH          = 16,
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 32,
    parameter int OUT_SCALE         = 0,
    parameter int PIPE_TREE         = 1
) (
    input  logic                           clk,
    input  logic                           arst_in,
    input  logic signed [IN_WIDTH-1:0]     I_in [N_LANES-1:0],
    input  logic signed [IN_WIDTH-1:0]     K_in [N_LANES-1:0],
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int c_LEVELS = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int c_T      = (PIPE_TREE != 0) ? c_LEVELS : 1;

`ifdef SATURATE_EN
    localparam logic signed [ACCUMULATOR_WIDTH-1:0] c_SAT_MAX =
        ACCUMULATOR_WIDTH'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACCUMULATOR_WIDTH-1:0] c_SAT_MIN = ~c_SAT_MAX;
`endif

    logic w_stall;
    logic w_accept;

    logic signed [ACCUMULATOR_WIDTH-1:0] prod_q [N_LANES];
    logic signed [ACCUMULATOR_WIDTH-1:0] prod_d [N_LANES];
    logic signed [2*IN_WIDTH-1:0]        a_ext, b_ext, p_full;

    // Index 0 tracks the multiplier stage, index c_T the tree output.
    logic [c_T:0] vld_q, vld_d, lst_q, lst_d;

    logic signed [ACCUMULATOR_WIDTH-1:0] tree_sum;
    logic signed [ACCUMULATOR_WIDTH-1:0] acc_q, acc_d, acc_n;
    logic                                empty_q, empty_d;
    logic                                out_valid_q, out_valid_d;
    logic signed [OUTPUT_WIDTH-1:0]      out_data_q, out_data_d;

    assign w_stall   = out_valid_q & ~out_ready;
    assign w_accept  = in_valid & ~w_stall;
    assign in_ready  = ~w_stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    function automatic logic signed [OUTPUT_WIDTH-1:0] f_conv(
        input logic signed [ACCUMULATOR_WIDTH-1:0] x
    );
        logic signed [ACCUMULATOR_WIDTH-1:0] sh;
        sh = x >>> OUT_SCALE;
`ifdef SATURATE_EN
        if (sh > c_SAT_MAX) begin
            sh = c_SAT_MAX;
        end else if (sh < c_SAT_MIN) begin
            sh = c_SAT_MIN;
        end
`endif
        return OUTPUT_WIDTH'(sh);
    endfunction

    always_comb begin
        a_ext  = '0;
        b_ext  = '0;
        p_full = '0;
        for (int i = 0; i < N_LANES; i++) begin
            a_ext     = (2*IN_WIDTH)'(I_in[i]);
            b_ext     = (2*IN_WIDTH)'(K_in[i]);
            p_full    = a_ext * b_ext;
            prod_d[i] = w_accept ? ACCUMULATOR_WIDTH'(p_full) : prod_q[i];
        end
    end

    always_comb begin
        vld_d = vld_q;
        lst_d = lst_q;
        if (!w_stall) begin
            vld_d = {vld_q[c_T-1:0], w_accept};
            lst_d = {lst_q[c_T-1:0], w_accept & in_last};
        end
    end

    // Pairwise reduction; an odd trailing node passes through to the next level.
    genvar l, j;
    generate
        for (l = 1; l <= c_LEVELS; l++) begin : g_lvl
            localparam int c_CNT_IN  = (N_LANES + (1 << (l - 1)) - 1) >> (l - 1);
            localparam int c_CNT_OUT = (N_LANES + (1 << l) - 1) >> l;

            logic signed [ACCUMULATOR_WIDTH-1:0] src    [c_CNT_IN];
            logic signed [ACCUMULATOR_WIDTH-1:0] node_d [c_CNT_OUT];
            logic signed [ACCUMULATOR_WIDTH-1:0] node   [c_CNT_OUT];

            if (l == 1) begin : g_src_mul
                assign src = prod_q;
            end else begin : g_src_lvl
                assign src = g_lvl[l-1].node;
            end

            for (j = 0; j < c_CNT_OUT; j++) begin : g_node
                if (2*j + 1 < c_CNT_IN) begin : g_add
                    assign node_d[j] = src[2*j] + src[2*j+1];
                end else begin : g_fwd
                    assign node_d[j] = src[2*j];
                end
            end

            if (PIPE_TREE != 0) begin : g_reg
                logic signed [ACCUMULATOR_WIDTH-1:0] node_q [c_CNT_OUT];
                always_ff @(posedge clk or posedge arst_in) begin
                    if (arst_in) begin
                        for (int k = 0; k < c_CNT_OUT; k++) begin
                            node_q[k] <= '0;
                        end
                    end else if (!w_stall) begin
                        node_q <= node_d;
                    end
                end
                assign node = node_q;
            end else begin : g_comb
                assign node = node_d;
            end
        end

        if (PIPE_TREE != 0) begin : g_tree_piped
            assign tree_sum = g_lvl[c_LEVELS].node[0];
        end else begin : g_tree_flat
            logic signed [ACCUMULATOR_WIDTH-1:0] sum_q, sum_d;
            assign sum_d = w_stall ? sum_q : g_lvl[c_LEVELS].node[0];
            always_ff @(posedge clk or posedge arst_in) begin
                if (arst_in) begin
                    sum_q <= '0;
                end else begin
                    sum_q <= sum_d;
                end
            end
            assign tree_sum = sum_q;
        end
    endgenerate

    always_comb begin
        acc_d       = acc_q;
        empty_d     = empty_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_n       = empty_q ? tree_sum : acc_q + tree_sum;
        if (!w_stall) begin
            out_valid_d = 1'b0;
            if (vld_q[c_T]) begin
                if (lst_q[c_T]) begin
                    out_data_d  = f_conv(acc_n);
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    empty_d     = 1'b1;
                end else begin
                    acc_d   = acc_n;
                    empty_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            for (int i = 0; i < N_LANES; i++) begin
                prod_q[i] <= '0;
            end
            vld_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            empty_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            prod_q      <= prod_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            acc_q       <= acc_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
`default_nettype wire
